stall_ctrl: RTL and testbench
=============================

STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 SHALL: clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-high; clears all state.
REQ-003 SHALL: fd_ir  input  32  instruction in F/D latch.
REQ-004 SHALL: dx_ir  input  32  instruction in D/X latch.
REQ-005 SHALL: branch_taken  input  1  D/X control-flow redirect (taken bne/blt, jr, bex).
REQ-006 SHALL: md_ready  input  1  multdiv result_ready.
REQ-007 SHALL: md_exception  input  1  multdiv data_exception; valid with md_ready.
REQ-008 SHALL: pc_en, fd_en, dx_en  output  1 each  latch load enables; default 1.
REQ-009 SHALL: fd_flush, dx_nop, xm_nop  output  1 each  force 32'b0 into F/D, D/X, X/M; default 0.
REQ-010 SHALL: ctrl_mult, ctrl_div  output  1 each  one-cycle multdiv start pulses; default 0.
REQ-011 SHALL: md_wb_sel  output  1  X/M takes multdiv result instead of ALU result; default 0.
REQ-012 SHALL: md_ovf  output  1  multdiv exception qualified by completion; default 0.
REQ-013 SHALL: md_timeout  output  1  sticky flag, BUSY exceeded 63 cycles; default 0.

Function
REQ-014 SHALL decode opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALU op [6:2]; mul = R-type (00000) with ALU op 00110, div = R-type with ALU op 00111.
REQ-015 SHALL flag load-use when dx opcode = 01000 (lw), dx rd != 0, and dx rd matches an fd source: rs and rt for R-type; rs for addi/lw; rs and rd for sw (00111), bne (00010), blt (00110); rd for jr (00100).
REQ-016 SHALL, on load-use: pc_en=0, fd_en=0, dx_nop=1, for exactly one cycle.
REQ-017 SHALL, on branch_taken: fd_flush=1 and dx_nop=1 in that cycle; pc_en, fd_en stay 1.
REQ-018 SHALL implement FSM IDLE, START, BUSY, DONE; 2-bit state register.
REQ-019 IDLE: on dx mul/div -> START; otherwise remain.
REQ-020 START: ctrl_mult or ctrl_div =1 (per decode) for this cycle only; pc_en=fd_en=dx_en=0; xm_nop=1; -> BUSY.
REQ-021 BUSY: pc_en=fd_en=dx_en=0, xm_nop=1; 6-bit cycle counter increments; md_ready=1 -> DONE; counter reaches 63 without md_ready -> set md_timeout, -> DONE.
REQ-022 DONE: md_wb_sel=1, md_ovf = md_exception & md_ready, xm_nop=0, enables=1, dx_nop=1 (retire mul/div from D/X); -> IDLE.
REQ-023 Counter SHALL clear on entry to START and saturate at 63; no wrap.
REQ-024 Priority SHALL be: reset > multdiv FSM (START/BUSY) > branch_taken > load-use.
REQ-025 Load-use and branch_taken in same cycle: flush only; fd instruction discarded, no stall.
REQ-026 md_ready asserted in IDLE or START SHALL be ignored.
REQ-027 md_timeout SHALL clear only on reset.
REQ-028 All outputs except md_timeout SHALL be combinational from state and inputs; no output depends on a cycle-delayed input other than through state.

Reset
REQ-029 Reset SHALL force state=IDLE, counter=0, md_timeout=0 immediately, independent of clock.
REQ-030 Reset mid-BUSY SHALL abort sequencing; no ctrl_mult/ctrl_div pulse while or after reset until a new mul/div reaches D/X.
REQ-031 During reset, outputs SHALL hold defaults (enables 1, all others 0).

Structure
REQ-032 Opcode, ALU-op and FSM state encodings SHALL reside in the shared ISA definitions package, reused by the processor decode.
REQ-033 Load-use detection SHALL be one combinational sub-module, ld_use_detect; FSM and counter stay in stall_ctrl.

Verification
REQ-034 lw $3,0($1) in dx, add $4,$3,$2 in fd -> one cycle pc_en=0, fd_en=0, dx_nop=1; next cycle all enables 1.
REQ-035 lw $0 in dx, fd reads $0 -> no stall.
REQ-036 mul $5,$6,$7 in dx, md_ready at 17th BUSY cycle -> ctrl_mult single pulse in START, 17 stall cycles, DONE with md_wb_sel=1, back to IDLE.
REQ-037 div with md_ready=1 and md_exception=1 -> md_ovf=1 in DONE only; div by md_ready never asserted -> md_timeout=1 after 63 BUSY cycles, sticky.
REQ-038 branch_taken=1 concurrent with load-use pattern -> fd_flush=1, dx_nop=1, pc_en=1.
REQ-039 reset pulse at BUSY cycle 10 -> state IDLE, outputs default immediately; no ctrl_mult/ctrl_div until next mul/div.

Source files
------------

// File: rtl/stall_ctrl_pkg.sv
// stall_ctrl_pkg: shared ISA encodings, field decode helpers and multdiv FSM states
package stall_ctrl_pkg;
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_JR = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT = 5'b00110;
  localparam logic [4:0] OP_SW = 5'b00111;
  localparam logic [4:0] OP_LW = 5'b01000;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;
  localparam logic [5:0] MD_LIMIT = 6'd63;
  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} md_state_t;
  function automatic logic [4:0] f_op(input logic [31:0] ir);
    return ir[31:27];
  endfunction
  function automatic logic [4:0] f_rd(input logic [31:0] ir);
    return ir[26:22];
  endfunction
  function automatic logic [4:0] f_rs(input logic [31:0] ir);
    return ir[21:17];
  endfunction
  function automatic logic [4:0] f_rt(input logic [31:0] ir);
    return ir[16:12];
  endfunction
  function automatic logic [4:0] f_alu(input logic [31:0] ir);
    return ir[6:2];
  endfunction
  function automatic logic is_mul(input logic [31:0] ir);
    return f_op(ir) == OP_RTYPE && f_alu(ir) == ALU_MUL;
  endfunction
  function automatic logic is_div(input logic [31:0] ir);
    return f_op(ir) == OP_RTYPE && f_alu(ir) == ALU_DIV;
  endfunction
endpackage

// File: rtl/stall_ctrl_ld_use_detect.sv
// ld_use_detect: flags a lw in D/X whose destination feeds a source of the F/D instruction
module ld_use_detect
  import stall_ctrl_pkg::*;
(
  input  logic [31:0] fd_ir,
  input  logic [31:0] dx_ir,
  output logic        load_use
);
  logic [4:0] fo, d;
  logic uses_rs, uses_rt, uses_rd;
  logic unused_bits;
  assign fo = f_op(fd_ir);
  assign d = f_rd(dx_ir);
  // sw and branches read rd as a source operand
  assign uses_rs = fo inside {OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BNE, OP_BLT};
  assign uses_rt = fo == OP_RTYPE;
  assign uses_rd = fo inside {OP_SW, OP_BNE, OP_BLT, OP_JR};
  assign load_use = f_op(dx_ir) == OP_LW && d != 5'd0 &&
                    (uses_rs && f_rs(fd_ir) == d || uses_rt && f_rt(fd_ir) == d || uses_rd && f_rd(fd_ir) == d);
  assign unused_bits = ^{fd_ir[11:0], dx_ir[21:0]};
endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline hazard control -- load-use stall, branch flush and multdiv sequencing
module stall_ctrl
  import stall_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_ir,
  input  logic [31:0] dx_ir,
  input  logic        branch_taken,
  input  logic        md_ready,
  input  logic        md_exception,
  output logic        pc_en,
  output logic        fd_en,
  output logic        dx_en,
  output logic        fd_flush,
  output logic        dx_nop,
  output logic        xm_nop,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        md_wb_sel,
  output logic        md_ovf,
  output logic        md_timeout
);
  md_state_t state;
  logic [5:0] cnt;
  logic load_use, idle, start, stall, done, hold;
  ld_use_detect u_ld_use (.fd_ir(fd_ir), .dx_ir(dx_ir), .load_use(load_use));
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      md_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (is_mul(dx_ir) || is_div(dx_ir)) begin
          state <= START;
          cnt <= '0;
        end
        START: state <= BUSY;
        BUSY: begin
          cnt <= cnt == MD_LIMIT ? cnt : cnt + 6'd1;
          if (md_ready) state <= DONE;
          else if (cnt == MD_LIMIT - 6'd1) begin
            md_timeout <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  // reset masks every combinational output back to its default
  assign idle = !reset && state == IDLE;
  assign start = !reset && state == START;
  assign stall = start || (!reset && state == BUSY);
  assign done = !reset && state == DONE;
  assign hold = stall || idle && !branch_taken && load_use;
  assign pc_en = !hold;
  assign fd_en = !hold;
  assign dx_en = !stall;
  assign fd_flush = (idle || done) && branch_taken;
  assign dx_nop = done || idle && (branch_taken || load_use);
  assign xm_nop = stall;
  assign ctrl_mult = start && is_mul(dx_ir);
  assign ctrl_div = start && is_div(dx_ir);
  assign md_wb_sel = done;
  assign md_ovf = done && md_exception && md_ready;
endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: directed and randomized checks of stall_ctrl against a behavioural model
module tb_stall_ctrl;
  logic clock = 1'b0, reset;
  logic [31:0] fd_ir, dx_ir;
  logic branch_taken, md_ready, md_exception;
  logic pc_en, fd_en, dx_en, fd_flush, dx_nop, xm_nop, ctrl_mult, ctrl_div, md_wb_sel, md_ovf, md_timeout;
  int n_chk = 0, n_pass = 0;
  int t;
  bit m_done, m_to;

  stall_ctrl dut (
    .clock(clock), .reset(reset), .fd_ir(fd_ir), .dx_ir(dx_ir), .branch_taken(branch_taken),
    .md_ready(md_ready), .md_exception(md_exception), .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en),
    .fd_flush(fd_flush), .dx_nop(dx_nop), .xm_nop(xm_nop), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
    .md_wb_sel(md_wb_sel), .md_ovf(md_ovf), .md_timeout(md_timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, rd, rs, rt, alu);
    return {op, rd, rs, rt, 5'd0, alu, 2'b00};
  endfunction

  function automatic bit md_op(input logic [31:0] ir);
    return ir[31:27] == 5'd0 && (ir[6:2] == 5'd6 || ir[6:2] == 5'd7);
  endfunction

  // which registers each F/D opcode reads, checked against the lw destination
  function automatic bit lu(input logic [31:0] fd, input logic [31:0] dx);
    logic [4:0] r;
    r = dx[26:22];
    if (dx[31:27] != 5'd8 || r == 5'd0) return 0;
    case (fd[31:27])
      5'd0: return fd[21:17] == r || fd[16:12] == r;
      5'd5, 5'd8: return fd[21:17] == r;
      5'd7, 5'd2, 5'd6: return fd[21:17] == r || fd[26:22] == r;
      5'd4: return fd[26:22] == r;
      default: return 0;
    endcase
  endfunction

  // t: -1 idle, 0 start cycle, k>=1 the k-th busy cycle; m_done marks the retire cycle
  function automatic logic [9:0] expect_outs();
    bit mul_, div_;
    mul_ = dx_ir[31:27] == 5'd0 && dx_ir[6:2] == 5'd6;
    div_ = dx_ir[31:27] == 5'd0 && dx_ir[6:2] == 5'd7;
    if (reset) return 10'b1110000000;
    if (t == 0) return {6'b000001, mul_, div_, 2'b00};
    if (t > 0) return 10'b0000010000;
    if (m_done) return {3'b111, branch_taken, 5'b10001, md_exception & md_ready};
    if (branch_taken) return 10'b1111100000;
    if (lu(fd_ir, dx_ir)) return 10'b0010100000;
    return 10'b1110000000;
  endfunction

  task automatic model_reset();
    t = -1;
    m_done = 0;
    m_to = 0;
  endtask

  task automatic model_step();
    if (reset) model_reset();
    else if (m_done) m_done = 0;
    else if (t == -1) t = md_op(dx_ir) ? 0 : -1;
    else if (t == 0) t = 1;
    else if (md_ready) begin m_done = 1; t = -1; end
    else if (t == 63) begin m_done = 1; m_to = 1; t = -1; end
    else t++;
  endtask

  task automatic cycle();
    #3;
    chk("outs", {22'd0, pc_en, fd_en, dx_en, fd_flush, dx_nop, xm_nop, ctrl_mult, ctrl_div, md_wb_sel, md_ovf},
        {22'd0, expect_outs()});
    chk("timeout", {31'd0, md_timeout}, {31'd0, m_to});
    @(posedge clock);
    model_step();
    #1;
  endtask

  // runs one mul/div to completion; ready_at=0 means md_ready never comes
  task automatic run_md(input logic [31:0] ir, input int ready_at, input bit ex, input int abort_at);
    bit fin, was_done;
    fin = 0;
    dx_ir = ir;
    fd_ir = '0;
    branch_taken = 0;
    md_exception = ex;
    for (int k = 0; k < 100 && !fin; k++) begin
      was_done = m_done;
      if (abort_at > 0 && t == abort_at) begin
        reset = 1;
        #1 reset = 0;
        model_reset();
        dx_ir = '0;
        md_ready = 0;
        cycle();
        fin = 1;
      end else begin
        md_ready = ready_at > 0 && (t == ready_at || m_done || t <= 0);
        cycle();
        if (was_done) begin
          dx_ir = '0;
          md_ready = 0;
          fin = 1;
        end
      end
    end
    chk("md_end", {31'd0, fin}, 32'd1);
  endtask

  function automatic logic [31:0] rand_ir();
    logic [4:0] op;
    case ($urandom_range(0, 7))
      0: op = 5'd0;
      1: op = 5'd5;
      2: op = 5'd8;
      3: op = 5'd7;
      4: op = 5'd2;
      5: op = 5'd6;
      6: op = 5'd4;
      default: op = 5'd1;
    endcase
    return mk(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 1)));
  endfunction

  initial begin
    model_reset();
    reset = 1;
    dx_ir = mk(5'd8, 5'd3, 5'd1, 5'd0, 5'd0);
    fd_ir = mk(5'd0, 5'd4, 5'd3, 5'd2, 5'd0);
    branch_taken = 1;
    md_ready = 1;
    md_exception = 1;
    @(posedge clock);
    #1;
    cycle();
    cycle();
    reset = 0;
    branch_taken = 0;
    md_ready = 0;
    md_exception = 0;
    cycle();
    dx_ir = '0;
    cycle();
    dx_ir = mk(5'd8, 5'd0, 5'd1, 5'd0, 5'd0);
    fd_ir = mk(5'd0, 5'd4, 5'd0, 5'd0, 5'd0);
    cycle();
    dx_ir = mk(5'd8, 5'd3, 5'd1, 5'd0, 5'd0);
    fd_ir = mk(5'd0, 5'd4, 5'd3, 5'd2, 5'd0);
    branch_taken = 1;
    cycle();
    branch_taken = 0;
    fd_ir = mk(5'd4, 5'd3, 5'd0, 5'd0, 5'd0);
    cycle();
    run_md(mk(5'd0, 5'd5, 5'd6, 5'd7, 5'd6), 17, 0, 0);
    cycle();
    run_md(mk(5'd0, 5'd5, 5'd6, 5'd7, 5'd7), 5, 1, 0);
    run_md(mk(5'd0, 5'd5, 5'd6, 5'd7, 5'd7), 0, 0, 0);
    repeat (3) cycle();
    run_md(mk(5'd0, 5'd1, 5'd2, 5'd3, 5'd6), 3, 0, 0);
    run_md(mk(5'd0, 5'd1, 5'd2, 5'd3, 5'd6), 20, 0, 10);
    repeat (5) cycle();
    for (int i = 0; i < 600; i++) begin
      fd_ir = rand_ir();
      dx_ir = $urandom_range(0, 7) == 0 ? mk(5'd0, 5'd1, 5'd2, 5'd3, 5'($urandom_range(6, 7))) : rand_ir();
      branch_taken = $urandom_range(0, 7) == 0;
      md_ready = $urandom_range(0, 5) == 0;
      md_exception = 1'($urandom_range(0, 1));
      cycle();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
